// File: rtl/mux_2_1_tdm_sequencer_pkg.sv
// Shared types and constants for the 2:1 mux TDM sequencer.
package mux_tdm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int unsigned GAP_CYCLES_MAX = 3;

    // Out-of-range gap settings saturate to the longest legal gap.
    function automatic int unsigned gap_clamp(input int unsigned g);
        return (g > GAP_CYCLES_MAX) ? GAP_CYCLES_MAX : g;
    endfunction

endpackage

// File: rtl/mux_2_1_tdm_sequencer_if.sv
// Request/dwell inputs and mux control outputs of the TDM sequencer.
interface mux_2_1_tdm_sequencer_if #(
    parameter int unsigned DWELL_WIDTH = 8
);
    logic                   Req_0_In;
    logic                   Req_1_In;
    logic [DWELL_WIDTH-1:0] Dwell_In;
    logic                   Select_Out;
    logic                   Enable_Out;
    logic                   Ack_0_Out;
    logic                   Ack_1_Out;
    logic                   Busy_Out;

    modport slave (
        input  Req_0_In, Req_1_In, Dwell_In,
        output Select_Out, Enable_Out, Ack_0_Out, Ack_1_Out, Busy_Out
    );

    modport master (
        output Req_0_In, Req_1_In, Dwell_In,
        input  Select_Out, Enable_Out, Ack_0_Out, Ack_1_Out, Busy_Out
    );
endinterface

// File: rtl/mux_2_1_tdm_sequencer_rr_arbiter_2.sv
// Combinational two-requester round-robin arbiter.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_ch
);
    always_comb begin
        grant_valid = |req;
        grant_ch    = 1'b0;
        if (&req) begin
            grant_ch = ~last;
        end else if (req[1]) begin
            grant_ch = 1'b1;
        end
    end
endmodule

// File: rtl/mux_2_1_tdm_sequencer.sv
// Round-robin time-sharing controller for a 2:1 mux: grant, dwell, ack, gap.
module mux_2_1_tdm_sequencer #(
    parameter int unsigned DWELL_WIDTH = 8,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                    Clock_In,
    input  logic                    Reset_In,
    mux_2_1_tdm_sequencer_if.slave  bus
);
    import mux_tdm_pkg::*;

    localparam logic [1:0]             GAP_LOAD  = 2'(gap_clamp(GAP_CYCLES));
    localparam logic [1:0]             ABORT_GAP = (GAP_LOAD == 2'd0) ? 2'd1 : GAP_LOAD;
    localparam logic [DWELL_WIDTH-1:0] CNT_ONE   = DWELL_WIDTH'(1);
    localparam logic [DWELL_WIDTH-1:0] CNT_TWO   = DWELL_WIDTH'(2);

    state_t                 state;
    logic                   sel;
    logic                   en;
    logic                   ack_0;
    logic                   ack_1;
    logic                   busy;
    logic                   last;
    logic [DWELL_WIDTH-1:0] cnt;
    logic [1:0]             gap_cnt;

    logic                   grant_valid;
    logic                   grant_ch;
    logic                   granted_req;
    logic                   arb_point;
    logic [DWELL_WIDTH-1:0] dwell_eff;

    rr_arbiter_2 u_arb (
        .req         ({bus.Req_1_In, bus.Req_0_In}),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_ch    (grant_ch)
    );

    always_comb begin
        granted_req = sel ? bus.Req_1_In : bus.Req_0_In;
        dwell_eff   = (bus.Dwell_In == '0) ? CNT_ONE : bus.Dwell_In;
        arb_point   = (state == IDLE)
                   || (state == GAP && gap_cnt == 2'd1)
                   || (state == GRANT && cnt == CNT_ONE && GAP_LOAD == 2'd0);
    end

    // Ack and last-served are set one edge early so the ack lands in the final
    // enabled cycle and a zero-gap re-arbitration already sees the new owner.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state   <= IDLE;
            sel     <= 1'b0;
            en      <= 1'b0;
            ack_0   <= 1'b0;
            ack_1   <= 1'b0;
            busy    <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            gap_cnt <= '0;
        end else begin
            ack_0 <= 1'b0;
            ack_1 <= 1'b0;
            if (arb_point) begin
                if (grant_valid) begin
                    state <= GRANT;
                    sel   <= grant_ch;
                    en    <= 1'b1;
                    busy  <= 1'b1;
                    cnt   <= dwell_eff;
                    if (dwell_eff == CNT_ONE) begin
                        ack_0 <= ~grant_ch;
                        ack_1 <= grant_ch;
                        last  <= grant_ch;
                    end
                end else begin
                    state <= IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    GRANT: begin
                        if (cnt == CNT_ONE) begin
                            state   <= GAP;
                            en      <= 1'b0;
                            gap_cnt <= GAP_LOAD;
                        end else if (!granted_req) begin
                            state   <= GAP;
                            en      <= 1'b0;
                            gap_cnt <= ABORT_GAP;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                            if (cnt == CNT_TWO) begin
                                ack_0 <= ~sel;
                                ack_1 <= sel;
                                last  <= sel;
                            end
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.Select_Out = sel;
    assign bus.Enable_Out = en;
    assign bus.Ack_0_Out  = ack_0;
    assign bus.Ack_1_Out  = ack_1;
    assign bus.Busy_Out   = busy;

endmodule

// File: tb/tb_mux_2_1_tdm_sequencer.sv
// Directed bench: one sequencer with a 1-cycle gap, one with back-to-back slots.
module tb_mux_2_1_tdm_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic ch;

    always #5 clk = ~clk;

    mux_2_1_tdm_sequencer_if #(.DWELL_WIDTH(8)) bus1 ();
    mux_2_1_tdm_sequencer_if #(.DWELL_WIDTH(8)) bus0 ();

    mux_2_1_tdm_sequencer #(.DWELL_WIDTH(8), .GAP_CYCLES(1)) dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus1)
    );

    mux_2_1_tdm_sequencer #(.DWELL_WIDTH(8), .GAP_CYCLES(0)) dut_nogap (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus0)
    );

    // Expected output vector: {select, enable, ack_0, ack_1, busy}
    function automatic logic [4:0] ev(input logic s, input logic e, input logic a0,
                                      input logic a1, input logic b);
        return {s, e, a0, a1, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bus1.Select_Out, bus1.Enable_Out, bus1.Ack_0_Out, bus1.Ack_1_Out, bus1.Busy_Out};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (sel,en,ack0,ack1,busy)", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bus0.Select_Out, bus0.Enable_Out, bus0.Ack_0_Out, bus0.Ack_1_Out, bus0.Busy_Out};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (sel,en,ack0,ack1,busy)", tag, obs, exp);
        end
    endtask

    initial begin
        bus1.Req_0_In = 1'b0;
        bus1.Req_1_In = 1'b0;
        bus1.Dwell_In = 8'd0;
        bus0.Req_0_In = 1'b0;
        bus0.Req_1_In = 1'b0;
        bus0.Dwell_In = 8'd0;
        tick();
        tick();
        chk1("reset_state", ev(0, 0, 0, 0, 0));
        chk0("reset_state_nogap", ev(0, 0, 0, 0, 0));
        rst = 1'b0;

        // 1: single request, dwell 3
        bus1.Req_0_In = 1'b1;
        bus1.Dwell_In = 8'd3;
        tick(); chk1("t1_c1", ev(0, 1, 0, 0, 1));
        tick(); chk1("t1_c2", ev(0, 1, 0, 0, 1));
        tick(); chk1("t1_c3_ack", ev(0, 1, 1, 0, 1));
        bus1.Req_0_In = 1'b0;
        tick(); chk1("t1_c4_gap", ev(0, 0, 0, 0, 1));
        tick(); chk1("t1_c5_idle", ev(0, 0, 0, 0, 0));

        // 2: both requesting from reset -> 0,1,0,1 with a 1-cycle gap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus1.Req_0_In = 1'b1;
        bus1.Req_1_In = 1'b1;
        bus1.Dwell_In = 8'd2;
        for (int k = 0; k < 4; k++) begin
            ch = 1'(k % 2);
            tick(); chk1("t2_on", ev(ch, 1, 0, 0, 1));
            tick(); chk1("t2_ack", ev(ch, 1, ~ch, ch, 1));
            tick(); chk1("t2_gap", ev(ch, 0, 0, 0, 1));
        end
        bus1.Req_0_In = 1'b0;
        bus1.Req_1_In = 1'b0;
        tick(); chk1("t2_idle", ev(1, 0, 0, 0, 0));

        // 3: dwell 0 acts as 1; dwell change mid-slot ignored
        bus1.Req_0_In = 1'b1;
        bus1.Dwell_In = 8'd0;
        tick(); chk1("t3_dwell0_ack", ev(0, 1, 1, 0, 1));
        bus1.Req_0_In = 1'b0;
        tick(); chk1("t3_dwell0_gap", ev(0, 0, 0, 0, 1));
        bus1.Req_0_In = 1'b1;
        bus1.Dwell_In = 8'd5;
        tick(); chk1("t3_d5_c1", ev(0, 1, 0, 0, 1));
        bus1.Dwell_In = 8'd9;
        for (int k = 2; k <= 4; k++) begin
            tick(); chk1("t3_d5_mid", ev(0, 1, 0, 0, 1));
        end
        tick(); chk1("t3_d5_c5_ack", ev(0, 1, 1, 0, 1));
        bus1.Req_0_In = 1'b0;
        tick(); chk1("t3_d5_gap", ev(0, 0, 0, 0, 1));
        tick(); chk1("t3_idle", ev(0, 0, 0, 0, 0));

        // 4: channel 1 aborts; it still wins the next contention
        bus1.Req_1_In = 1'b1;
        bus1.Dwell_In = 8'd4;
        tick(); chk1("t4_c1", ev(1, 1, 0, 0, 1));
        tick(); chk1("t4_c2", ev(1, 1, 0, 0, 1));
        bus1.Req_1_In = 1'b0;
        tick(); chk1("t4_abort", ev(1, 0, 0, 0, 1));
        bus1.Req_0_In = 1'b1;
        bus1.Req_1_In = 1'b1;
        tick(); chk1("t4_ch1_wins", ev(1, 1, 0, 0, 1));

        // 5: asynchronous reset mid-slot, then channel 0 wins
        rst = 1'b1;
        #2;
        chk1("t5_async_rst", ev(0, 0, 0, 0, 0));
        rst = 1'b0;
        #1;
        chk1("t5_held_off", ev(0, 0, 0, 0, 0));
        tick(); chk1("t5_ch0_wins", ev(0, 1, 0, 0, 1));
        bus1.Req_0_In = 1'b0;
        bus1.Req_1_In = 1'b0;
        tick(); chk1("t5_abort", ev(0, 0, 0, 0, 1));
        tick(); chk1("t5_idle", ev(0, 0, 0, 0, 0));

        // 6: zero gap, dwell 1 -> enable stays high, select toggles each cycle
        bus0.Req_0_In = 1'b1;
        bus0.Req_1_In = 1'b1;
        bus0.Dwell_In = 8'd1;
        for (int k = 0; k < 6; k++) begin
            ch = 1'(k % 2);
            tick(); chk0("t6_b2b", ev(ch, 1, ~ch, ch, 1));
        end
        bus0.Req_0_In = 1'b0;
        bus0.Req_1_In = 1'b0;
        tick(); chk0("t6_idle", ev(1, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
